// File: rtl/scr1_dmi_chain_ctrl.sv
// DMI/DTMCS scan-chain controller: chain shift register, DMI request/response FSM, sticky status.
// Latency: capture/shift->ch_tdo_o 1 clk; update->dmi_req_o 1 clk; dmi_resp_i->dmi_req_o low 1 clk.
// Backpressure: DMI update while a request is outstanding sets sticky busy; updates dropped until dmireset.
module scr1_dmi_chain_ctrl #(
    parameter int unsigned DMI_AW      = 7,
    parameter int unsigned DMI_DW      = 32,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [1:0]  CH_ID_DTMCS = 2'd1,
    parameter logic [1:0]  CH_ID_DMI   = 2'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch_sel_i,
    input  logic [1:0]        ch_id_i,
    input  logic              ch_capture_i,
    input  logic              ch_shift_i,
    input  logic              ch_update_i,
    input  logic              ch_tdi_i,
    output logic              ch_tdo_o,
    output logic              dmi_req_o,
    output logic              dmi_wr_o,
    output logic [DMI_AW-1:0] dmi_addr_o,
    output logic [DMI_DW-1:0] dmi_wdata_o,
    input  logic              dmi_resp_i,
    input  logic [DMI_DW-1:0] dmi_rdata_i
);
    localparam int unsigned L        = DMI_AW + DMI_DW + 2;
    localparam logic [9:0]  TMO_LAST = 10'(TIMEOUT - 1);
    localparam logic [5:0]  ABITS    = 6'(DMI_AW);
    localparam logic [1:0]  STK_FAIL = 2'd2;
    localparam logic [1:0]  STK_BUSY = 2'd3;

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    typedef struct packed {
        logic              wr;
        logic [DMI_AW-1:0] addr;
        logic [DMI_DW-1:0] wdata;
    } dmi_req_t;

    state_t            state_q, state_d;
    logic [L-1:0]      shreg_q;
    logic [DMI_AW-1:0] last_addr_q;
    logic [DMI_DW-1:0] last_rdata_q;
    logic [1:0]        sticky_q;
    logic [9:0]        tmo_cnt_q;
    dmi_req_t          req_q;

    logic              sel_dmi, sel_dtm, sel_any;
    logic              upd, cap, sft;
    logic              hard_rst, soft_rst;
    logic              accept, busy_set, resp_take, tmo_hit;
    logic [1:0]        upd_op;
    logic [DMI_DW-1:0] upd_data;
    logic [DMI_AW-1:0] upd_addr;
    logic [31:0]       dtmcs_img;

    assign sel_dmi = ch_sel_i && (ch_id_i == CH_ID_DMI);
    assign sel_dtm = ch_sel_i && (ch_id_i == CH_ID_DTMCS);
    assign sel_any = sel_dmi || sel_dtm;

    // Only one strobe acts per cycle: update, then capture, then shift.
    assign upd = sel_any && ch_update_i;
    assign cap = sel_any && !ch_update_i && ch_capture_i;
    assign sft = sel_any && !ch_update_i && !ch_capture_i && ch_shift_i;

    assign hard_rst = upd && sel_dtm && shreg_q[17];
    assign soft_rst = upd && sel_dtm && shreg_q[16];

    assign upd_op   = shreg_q[1:0];
    assign upd_data = shreg_q[DMI_DW+1:2];
    assign upd_addr = shreg_q[L-1:DMI_DW+2];

    assign dtmcs_img = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, sticky_q, ABITS, 4'd1};

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        busy_set  = 1'b0;
        resp_take = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (hard_rst) begin
                    state_d = ST_IDLE;
                end else if (dmi_resp_i) begin
                    resp_take = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        // A response in this cycle frees the FSM, so the update is taken as if idle.
        if (upd && sel_dmi && (sticky_q == 2'd0)) begin
            if ((state_q == ST_REQ) && !resp_take) begin
                busy_set = 1'b1;
            end else if ((upd_op == 2'd1) || (upd_op == 2'd2)) begin
                accept  = 1'b1;
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            last_addr_q  <= '0;
            last_rdata_q <= '0;
            sticky_q     <= '0;
            tmo_cnt_q    <= '0;
            req_q        <= '0;
        end else begin
            state_q <= state_d;

            if (cap) begin
                shreg_q <= sel_dmi ? {last_addr_q, last_rdata_q, sticky_q}
                                   : {{(L-32){1'b0}}, dtmcs_img};
            end else if (sft) begin
                if (sel_dmi) shreg_q <= {ch_tdi_i, shreg_q[L-1:1]};
                else         shreg_q[31:0] <= {ch_tdi_i, shreg_q[31:1]};
            end

            if (accept) begin
                req_q.wr    <= (upd_op == 2'd2);
                req_q.addr  <= upd_addr;
                req_q.wdata <= upd_data;
                last_addr_q <= upd_addr;
                tmo_cnt_q   <= '0;
            end else if (state_q == ST_REQ) begin
                tmo_cnt_q <= tmo_cnt_q + 10'd1;
            end

            if (resp_take && !req_q.wr) last_rdata_q <= dmi_rdata_i;

            if (hard_rst || soft_rst) sticky_q <= '0;
            if (busy_set)             sticky_q <= STK_BUSY;
            if (tmo_hit)              sticky_q <= STK_FAIL;
        end
    end

    assign ch_tdo_o    = shreg_q[0];
    assign dmi_req_o   = (state_q == ST_REQ);
    assign dmi_wr_o    = req_q.wr;
    assign dmi_addr_o  = req_q.addr;
    assign dmi_wdata_o = req_q.wdata;

endmodule
